// File: rtl/hex_display_mux_if.sv
// Load channel for hex_display_mux: digit nibbles, decimal points and
// leading-zero blanking enable, transferred by a valid/ready handshake.
interface hex_display_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] i_data;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic                    i_blank_lz;
    logic                    i_valid;
    logic                    o_ready;

    modport master (
        output i_data,
        output i_dp,
        output i_blank_lz,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_data,
        input  i_dp,
        input  i_blank_lz,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/hex_display_mux.sv
// N-digit time-multiplexed 7-segment driver with one-deep load buffer,
// tear-free update at frame boundaries, decimal points, leading-zero
// blanking, PWM brightness and configurable output polarity.
module hex_display_mux #(
    parameter int NUM_DIGITS       = 8,
    parameter int DIV_WIDTH        = 14,
    parameter int BRIGHT_WIDTH     = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hex_display_mux_if.slave        load,
    input  logic [BRIGHT_WIDTH-1:0] i_brightness,
    output logic [NUM_DIGITS-1:0]   o_anodes,
    output logic [7:0]              o_segments,
    output logic                    o_frame
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [7:0]            SEG_OFF   = {8{SEG_ACTIVE_LOW}};

    logic [DIV_WIDTH-1:0]    cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    boundary;
    logic [BRIGHT_WIDTH-1:0] phase;
    logic                    anode_on;

    logic [4*NUM_DIGITS-1:0] disp_data, pend_data;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
    logic                    disp_blank, pend_blank;
    logic                    pend_valid;
    logic                    accept;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   anode_act;
    logic [7:0]              seg_act;

    assign tick         = &cnt;
    assign boundary     = tick && (idx == IDX_LAST);
    assign phase        = cnt[DIV_WIDTH-1 -: BRIGHT_WIDTH];
    assign anode_on     = phase < i_brightness;
    assign load.o_ready = !pend_valid;
    assign accept       = load.i_valid && !pend_valid;

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Free-running prescaler and digit index stepping once per slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // One-deep load buffer; display registers only change at a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= 1'b0;
            pend_valid <= 1'b0;
        end else if (boundary && pend_valid) begin
            disp_data  <= pend_data;
            disp_dp    <= pend_dp;
            disp_blank <= pend_blank;
            pend_valid <= 1'b0;
        end else if (accept) begin
            // An accept coinciding with a boundary lands here too, so it
            // waits for the following boundary instead of tearing this one.
            pend_data  <= load.i_data;
            pend_dp    <= load.i_dp;
            pend_blank <= load.i_blank_lz;
            pend_valid <= 1'b1;
        end
    end

    // Select current digit, track leading zeros from the top digit down, build anode vector
    always_comb begin : digit_select
        int unsigned k;
        logic        lead_zero;
        k         = 0;
        lead_zero = 1'b1;
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        anode_act = '0;
        for (int unsigned n = 0; n < NUM_DIGITS; n++) begin
            k         = NUM_DIGITS - 1 - n;
            lead_zero = lead_zero && (disp_data[4*k +: 4] == 4'h0);
            if (idx == IDX_W'(k)) begin
                cur_nib      = disp_data[4*k +: 4];
                cur_dp       = disp_dp[k];
                cur_blank    = disp_blank && lead_zero && (k != 0);
                anode_act[k] = anode_on;
            end
        end
        seg_act = (cur_blank ? 8'h00 : seg_encode(cur_nib)) | {7'b0, cur_dp};
    end

    // Registered pin drivers with polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_anodes   <= ANODE_OFF;
            o_segments <= SEG_OFF;
            o_frame    <= 1'b0;
        end else begin
            o_anodes   <= anode_act ^ ANODE_OFF;
            o_segments <= seg_act ^ SEG_OFF;
            o_frame    <= boundary;
        end
    end
endmodule
